// File: rtl/digital_tester_pkg.sv
// Shared types and default widths for the digital tester pin sequencing logic.
package digital_tester_pkg;

  // Default widths used by the sequencer and its bench
  localparam int unsigned DefDataW   = 31;
  localparam int unsigned DefPeriodW = 16;
  localparam int unsigned DefCountW  = 32;
  localparam int unsigned DefLevelW  = 32;

  // Width of the FIFO output data word feeding the sequencer
  localparam int unsigned FifoDataW  = 32;

  // Sequencer control states
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StHold   = 2'd2,
    StFinish = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_period_timer.sv
// Loadable down-counter that paces vectors while the sequencer sits in HOLD.
// expired is high whenever the count has reached zero; the count stops there.
module seq_period_timer #(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  output logic                expired
);

  localparam logic [PERIOD_W-1:0] PeriodOne = PERIOD_W'(1);

  logic [PERIOD_W-1:0] count_q;

  // Load takes priority over counting; otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - PeriodOne;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/vector_sequencer.sv
// Pops test vectors from the pin-domain side of the host FIFO and drives them
// onto the tester pin bus at a programmable rate. A run is started and aborted
// by one-cycle pulses and is either bounded by a vector count or runs until
// the FIFO reports empty. Status (busy/done/underrun/vec_count) goes to PIOs.
module vector_sequencer
  import digital_tester_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned LEVEL_W  = DefLevelW,
  parameter int unsigned PERIOD_W = DefPeriodW,
  parameter int unsigned COUNT_W  = DefCountW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PERIOD_W-1:0]  cfg_period,
  input  logic [COUNT_W-1:0]   cfg_count,
  input  logic [LEVEL_W-1:0]   fifo_level,
  input  logic [FifoDataW-1:0] fifo_data,
  input  logic                 fifo_valid,
  output logic                 fifo_ready,
  output logic [DATA_W-1:0]    pin_data,
  output logic                 pin_strobe,
  output logic                 pin_active,
  output logic                 busy,
  output logic                 done,
  output logic                 underrun,
  output logic [COUNT_W-1:0]   vec_count,
  output logic                 fifo_nonempty
);

  localparam logic [PERIOD_W-1:0] PerOne   = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] PerTwo   = PERIOD_W'(2);
  localparam logic [COUNT_W-1:0]  CountOne = COUNT_W'(1);

  seq_state_e          state_q;
  logic [PERIOD_W-1:0] per_q;
  logic [COUNT_W-1:0]  cnt_q;

  logic                transfer;
  logic                last_vec;
  logic [COUNT_W-1:0]  vec_count_inc;
  logic [PERIOD_W-1:0] per_start;
  logic                timer_load;
  logic [PERIOD_W-1:0] timer_load_val;
  logic                timer_expired;

  // Upper FIFO data bits beyond the pin width are intentionally dropped
  logic                unused_fifo_bits;
  assign unused_fifo_bits = ^fifo_data;

  // Pop request: only in FETCH, never in an abort cycle, never during reset
  assign fifo_ready    = reset_n && (state_q == StFetch) && !abort;
  assign transfer      = fifo_ready && fifo_valid;
  assign fifo_nonempty = (fifo_level != '0);
  assign busy          = (state_q != StIdle);

  assign vec_count_inc = vec_count + CountOne;
  // A bounded run ends on the transfer that brings the count up to cnt
  assign last_vec      = (cnt_q != '0) && (vec_count_inc == cnt_q);

  // A period of 0 behaves like 1 (one vector per clock)
  assign per_start     = (cfg_period == '0) ? PerOne : cfg_period;

  // FETCH and the transfer cycle account for two of the per cycles, HOLD the rest
  assign timer_load     = transfer && !last_vec && (per_q != PerOne);
  assign timer_load_val = per_q - PerTwo;

  seq_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .expired  (timer_expired)
  );

  // Run-control FSM with registered pin and status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      per_q      <= '0;
      cnt_q      <= '0;
      pin_data   <= '0;
      pin_strobe <= 1'b0;
      pin_active <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      vec_count  <= '0;
    end else begin
      pin_strobe <= 1'b0;
      done       <= 1'b0;

      unique case (state_q)
        StIdle: begin
          // start together with abort is treated as no request at all
          if (start && !abort) begin
            per_q     <= per_start;
            cnt_q     <= cfg_count;
            vec_count <= '0;
            underrun  <= 1'b0;
            state_q   <= StFetch;
          end
        end

        StFetch: begin
          if (abort) begin
            state_q <= StFinish;
            done    <= 1'b1;
          end else if (fifo_valid) begin
            pin_data   <= fifo_data[DATA_W-1:0];
            pin_strobe <= 1'b1;
            pin_active <= 1'b1;
            vec_count  <= vec_count_inc;
            if (last_vec) begin
              state_q <= StFinish;
              done    <= 1'b1;
            end else if (per_q != PerOne) begin
              state_q <= StHold;
            end
          end else if (fifo_level == '0) begin
            // Truly empty: expected end for unbounded runs, a shortfall otherwise
            if (cnt_q != '0) begin
              underrun <= 1'b1;
            end
            state_q <= StFinish;
            done    <= 1'b1;
          end
          // Level non-zero but no valid yet: FIFO read latency, keep waiting
        end

        StHold: begin
          if (abort) begin
            state_q <= StFinish;
            done    <= 1'b1;
          end else if (timer_expired) begin
            state_q <= StFetch;
          end
        end

        StFinish: begin
          pin_active <= 1'b0;
          state_q    <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
